// File: rtl/rs485_pkg.sv
// rs485_pkg -- shared definitions for the RS485 word transmitter.
//   SYNC_BYTE_DEFAULT : default frame header byte
//   FRAME_BYTES       : bytes per frame (header, data high, data low, check)
//   rs485_state_t     : frame sequencer states
//   frame_byte()      : selects the byte sent at a given frame position
package rs485_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_BYTES       = 4;

    typedef enum logic [2:0] {
        IDLE,
        DE_SETUP,
        START,
        DATA,
        STOP,
        DE_HOLD,
        DONE
    } rs485_state_t;

    function automatic logic [7:0] frame_byte(input logic [7:0]  sync,
                                              input logic [15:0] word,
                                              input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = sync;
            2'd1:    b = word[15:8];
            2'd2:    b = word[7:0];
            default: b = sync ^ word[15:8] ^ word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rs485_byte_ser.sv
// rs485_byte_ser -- 8N1 byte serializer, LSB first.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   load          : start a new byte (takes priority; may coincide with done)
//   byte_in       : byte to send, sampled when load=1
//   tx            : registered serial output, idle high
//   bit_tick      : high on the last cycle of every bit
//   done          : high on the last cycle of the stop bit
//   bit_idx       : current bit, 0 = start, 1..8 = data, 9 = stop
module rs485_byte_ser #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       bit_tick,
    output logic       done,
    output logic [3:0] bit_idx
);

    localparam int            CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);

    logic          active;
    logic [CW-1:0] cnt;
    logic [8:0]    shreg;   // remaining data bits with the stop bit on top

    assign bit_tick = active && (cnt == '0);
    assign done     = bit_tick && (bit_idx == 4'd9);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            active  <= 1'b0;
            cnt     <= '0;
            shreg   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else if (load) begin
            // Loading on the stop bit's last cycle keeps bytes gap-free.
            active  <= 1'b1;
            cnt     <= CNT_RELOAD;
            shreg   <= {1'b1, byte_in};
            bit_idx <= '0;
            tx      <= 1'b0;
        end else if (bit_tick) begin
            if (done) begin
                active  <= 1'b0;
                bit_idx <= '0;
                tx      <= 1'b1;
            end else begin
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
                bit_idx <= bit_idx + 4'd1;
                cnt     <= CNT_RELOAD;
            end
        end else if (active) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/rs485_word_tx.sv
// rs485_word_tx -- sends 16-bit words as 4-byte framed UART bursts on RS485.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   DATA_IN, VALID: word and its single-cycle strobe
//   OVR_CLR       : synchronous clear of OVERRUN (a same-cycle drop wins)
//   TX            : serial line, idle high
//   DE, RE_n      : transceiver enables (RE_n follows DE)
//   TX_BUSY       : high while a word is being or about to be sent
//   TX_COMPLETE   : one-cycle pulse at end of frame
//   OVERRUN       : sticky, set when a word is dropped
//
// state    | meaning
// IDLE     | line idle, DE low, waiting for VALID
// DE_SETUP | DE high, TX high for the guard time before the first start bit
// START    | start bit of the current byte
// DATA     | eight data bits of the current byte
// STOP     | stop bit; next byte loads on its last cycle
// DE_HOLD  | DE high, TX high for the guard time after the last stop bit
// DONE     | single cycle, DE low, TX_COMPLETE high
module rs485_word_tx
    import rs485_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         GUARD_BITS   = 2,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [15:0] DATA_IN,
    input  logic        VALID,
    input  logic        OVR_CLR,
    output logic        TX,
    output logic        DE,
    output logic        RE_n,
    output logic        TX_BUSY,
    output logic        TX_COMPLETE,
    output logic        OVERRUN
);

    localparam int            GUARD_CLKS   = GUARD_BITS * CLKS_PER_BIT;
    localparam int            GW           = $clog2(GUARD_CLKS);
    localparam logic [GW-1:0] GUARD_RELOAD = GW'(GUARD_CLKS - 1);
    localparam logic [1:0]    LAST_BYTE    = 2'(FRAME_BYTES - 1);

    rs485_state_t  state, state_nx;
    logic [15:0]   shift_word, shift_word_nx;
    logic [15:0]   pend_word, pend_word_nx;
    logic          pend_full, pend_full_nx;
    logic [1:0]    byte_idx, byte_idx_nx;
    logic [1:0]    byte_idx_inc;
    logic [GW-1:0] guard_cnt, guard_cnt_nx;
    logic          overrun_nx;
    logic          de_q, busy_q, complete_q, overrun_q;

    logic          ser_load;
    logic [7:0]    ser_byte;
    logic          ser_tick, ser_done;
    logic [3:0]    ser_bit_idx;

    assign byte_idx_inc = byte_idx + 2'd1;

    rs485_byte_ser #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_ser (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .load     (ser_load),
        .byte_in  (ser_byte),
        .tx       (TX),
        .bit_tick (ser_tick),
        .done     (ser_done),
        .bit_idx  (ser_bit_idx)
    );

    always_comb begin
        state_nx      = state;
        shift_word_nx = shift_word;
        pend_word_nx  = pend_word;
        pend_full_nx  = pend_full;
        byte_idx_nx   = byte_idx;
        guard_cnt_nx  = guard_cnt;
        overrun_nx    = overrun_q;
        ser_load      = 1'b0;
        ser_byte      = frame_byte(SYNC_BYTE, shift_word, 2'd0);

        if (OVR_CLR) begin
            overrun_nx = 1'b0;
        end

        // Words arriving mid-frame go to the one-entry buffer; IDLE and DONE
        // take VALID directly in the case below.
        if (VALID && (state != IDLE) && (state != DONE)) begin
            if (pend_full) begin
                overrun_nx = 1'b1;
            end else begin
                pend_word_nx = DATA_IN;
                pend_full_nx = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (VALID) begin
                    shift_word_nx = DATA_IN;
                    guard_cnt_nx  = GUARD_RELOAD;
                    state_nx      = DE_SETUP;
                end
            end
            DE_SETUP: begin
                if (guard_cnt == '0) begin
                    ser_load    = 1'b1;
                    byte_idx_nx = 2'd0;
                    state_nx    = START;
                end else begin
                    guard_cnt_nx = guard_cnt - GW'(1);
                end
            end
            START: begin
                if (ser_tick) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (ser_tick && (ser_bit_idx == 4'd8)) begin
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (ser_done) begin
                    if (byte_idx != LAST_BYTE) begin
                        ser_load    = 1'b1;
                        ser_byte    = frame_byte(SYNC_BYTE, shift_word, byte_idx_inc);
                        byte_idx_nx = byte_idx_inc;
                        state_nx    = START;
                    end else begin
                        guard_cnt_nx = GUARD_RELOAD;
                        state_nx     = DE_HOLD;
                    end
                end
            end
            DE_HOLD: begin
                if (guard_cnt == '0) begin
                    state_nx = DONE;
                end else begin
                    guard_cnt_nx = guard_cnt - GW'(1);
                end
            end
            DONE: begin
                guard_cnt_nx = GUARD_RELOAD;
                if (pend_full) begin
                    shift_word_nx = pend_word;
                    pend_full_nx  = 1'b0;
                    state_nx      = DE_SETUP;
                    if (VALID) begin
                        overrun_nx = 1'b1;
                    end
                end else if (VALID) begin
                    // Equivalent to buffering the word and sending it next,
                    // without a TX_BUSY dip through IDLE.
                    shift_word_nx = DATA_IN;
                    state_nx      = DE_SETUP;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            shift_word <= '0;
            pend_word  <= '0;
            pend_full  <= 1'b0;
            byte_idx   <= '0;
            guard_cnt  <= '0;
            overrun_q  <= 1'b0;
            de_q       <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state      <= state_nx;
            shift_word <= shift_word_nx;
            pend_word  <= pend_word_nx;
            pend_full  <= pend_full_nx;
            byte_idx   <= byte_idx_nx;
            guard_cnt  <= guard_cnt_nx;
            overrun_q  <= overrun_nx;
            // Outputs decoded from the next state so they are plain flops.
            de_q       <= (state_nx != IDLE) && (state_nx != DONE);
            busy_q     <= (state_nx != IDLE);
            complete_q <= (state_nx == DONE);
        end
    end

    assign DE          = de_q;
    assign RE_n        = de_q;
    assign TX_BUSY     = busy_q;
    assign TX_COMPLETE = complete_q;
    assign OVERRUN     = overrun_q;

endmodule

// File: doc/rs485_word_tx.md
RS485_WORD_TX -- requirements
Module: rs485_word_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning HCLK cycles per bit (50 MHz / 115200 baud); legal range 2..4095.
REQ-002 SHALL have parameter GUARD_BITS, default 2, meaning DE setup and hold time in bit periods; legal range 1..15.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame header byte.
REQ-004 HCLK  in  1  system clock, all logic on its rising edge.
REQ-005 HRESETn  in  1  reset, asynchronous, active-low.
REQ-006 DATA_IN  in  16  word to transmit; sampled only when VALID=1.
REQ-007 VALID  in  1  single-cycle strobe marking DATA_IN valid.
REQ-008 OVR_CLR  in  1  synchronous clear of OVERRUN.
REQ-009 TX  out  1  UART serial line to the RS485 transceiver; idle high.
REQ-010 DE  out  1  transceiver driver enable, active-high.
REQ-011 RE_n  out  1  transceiver receiver enable, active-low; equals DE.
REQ-012 TX_BUSY  out  1  high from word capture until TX_COMPLETE.
REQ-013 TX_COMPLETE  out  1  one-cycle pulse at the end of each frame.
REQ-014 OVERRUN  out  1  sticky flag, set when a word is dropped.

Function
REQ-015 Frame SHALL be 4 bytes in this order: SYNC_BYTE, DATA_IN[15:8], DATA_IN[7:0], CHK, where CHK = SYNC_BYTE ^ hi ^ lo.
REQ-016 Each byte SHALL be sent 8N1, LSB first: 1 start bit (0), 8 data bits, 1 stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-017 States SHALL be IDLE, DE_SETUP, START, DATA, STOP, DE_HOLD, DONE.
REQ-018 IDLE transitions:
- VALID=1 -> capture DATA_IN into the shift word, go to DE_SETUP.
- TX_BUSY and DE go high on the following cycle.
REQ-019 DE_SETUP SHALL hold TX=1 for GUARD_BITS*CLKS_PER_BIT cycles, then go to START with byte index 0.
REQ-020 Bit sequencing:
- START -> DATA -> STOP.
- After STOP: byte index<3 -> START with the next byte, no idle gap; index=3 -> DE_HOLD.
REQ-021 DE_HOLD SHALL hold TX=1 and DE=1 for GUARD_BITS*CLKS_PER_BIT cycles, then go to DONE.
REQ-022 DONE SHALL last 1 cycle with DE=0 and TX_COMPLETE=1.
- Pending buffer full -> load it, go to DE_SETUP (TX_BUSY stays 1).
- Otherwise go to IDLE (TX_BUSY=0).
REQ-023 A 1-entry pending buffer SHALL capture VALID while state≠IDLE; TX_BUSY stays high throughout.
REQ-024 VALID with the pending buffer already full SHALL drop the new word, keep the buffered word, and set OVERRUN.
REQ-025 VALID during DONE with the pending buffer full SHALL drop the word and set OVERRUN; the buffered word is still loaded.
REQ-026 VALID during DONE with the pending buffer empty SHALL be captured into the pending buffer and transmitted next.
REQ-027 OVR_CLR and an overrun on the same cycle SHALL leave OVERRUN=1 (set wins).
REQ-028 Bit counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, count down, and reload on every bit boundary; no wrap-around artefacts.
REQ-029 Total DE-high time per frame SHALL be (2*GUARD_BITS+40)*CLKS_PER_BIT cycles.

Reset
REQ-030 Asserting HRESETn low SHALL immediately force: TX=1, DE=0, RE_n=0, TX_BUSY=0, TX_COMPLETE=0, OVERRUN=0, state=IDLE, pending buffer empty, counters=0.
REQ-031 Reset mid-frame SHALL abort the frame with no TX_COMPLETE pulse; the first VALID after release starts a fresh frame.

Structure
REQ-032 Shared package rs485_pkg SHALL hold the state enumeration, SYNC_BYTE default, and frame length constant (4).
REQ-033 Sub-module rs485_byte_ser SHALL implement start/data/stop serialization with a load/done handshake; it is instantiated once.
REQ-034 Design size SHALL be 120-400 RTL lines; no clock gating; TX, DE, RE_n registered (glitch-free).

Verification (CLKS_PER_BIT=4, GUARD_BITS=1)
REQ-035 VALID with 16'h1234 -> bytes A5,12,34,83 on TX; DE high for exactly 168 cycles; TX_COMPLETE a single pulse.
REQ-036 16'h1234 then 16'hBEEF mid-frame -> two back-to-back frames, second CHK=A5^BE^EF=F4; TX_BUSY continuous; 2 TX_COMPLETE pulses.
REQ-037 Three VALIDs during one frame -> second word sent, third dropped, OVERRUN=1; OVR_CLR -> OVERRUN=0.
REQ-038 HRESETn low during byte 2 -> TX=1 and DE=0 asynchronously; no TX_COMPLETE; next VALID yields a correct full frame.
REQ-039 VALID and OVR_CLR coincident with a drop -> OVERRUN remains 1.
REQ-040 Bit-timing checker -> every bit edge lands on a multiple of 4 cycles from start; RE_n==DE on all cycles.
